// File: rtl/ft_host_framer_if.sv
// Bundle of the command, write-payload, byte-stream and response signals of
// the FT245 host framer; clk and rst stay outside as plain ports.
interface ft_host_framer_if;
  // Every valid/ready pair transfers on a rising edge where both are high.
  // A source holds its payload stable while valid is high and ready is low,
  // and valid never waits on ready. The two exceptions are wr_ready, a
  // one-cycle take pulse, and rx_ready, which stays high out of reset.
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_flags;
  logic [3:0]  cmd_code;
  logic [23:0] cmd_count;
  logic [31:0] cmd_address;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  rsp_status;
  logic [23:0] rsp_count;
  logic [31:0] rsp_address;
  logic [31:0] rsp_data;
  logic        rsp_data_valid;
  logic        rsp_done;
  logic        rsp_bad;
  logic [15:0] sync_drop;

  modport master (
    output cmd_valid, cmd_flags, cmd_code, cmd_count, cmd_address,
    output wr_data, wr_valid, tx_ready, rx_byte, rx_valid,
    input  cmd_ready, wr_ready, tx_byte, tx_valid, rx_ready,
    input  rsp_status, rsp_count, rsp_address, rsp_data,
    input  rsp_data_valid, rsp_done, rsp_bad, sync_drop
  );

  modport slave (
    input  cmd_valid, cmd_flags, cmd_code, cmd_count, cmd_address,
    input  wr_data, wr_valid, tx_ready, rx_byte, rx_valid,
    output cmd_ready, wr_ready, tx_byte, tx_valid, rx_ready,
    output rsp_status, rsp_count, rsp_address, rsp_data,
    output rsp_data_valid, rsp_done, rsp_bad, sync_drop
  );
endinterface

// File: rtl/ft_host_framer.sv
// Host-side FT245 sync-FIFO framer: serialises 0xCD command frames and
// parses 0xDC response frames. The TX and RX paths run independently.
module ft_host_framer #(
  parameter logic [7:0] CMD_ID = 8'hCD,
  parameter logic [7:0] RSP_ID = 8'hDC
) (
  input  logic              clk,
  input  logic              rst,
  ft_host_framer_if.slave   bus,
  output logic [2:0]        dbg_tx_state_o,
  output logic [1:0]        dbg_rx_state_o
);

  typedef enum logic [2:0] {TX_IDLE, TX_ID, TX_CMD, TX_ADDR, TX_DATA} tx_state_e;
  typedef enum logic [1:0] {RX_HUNT, RX_STATUS, RX_ADDR, RX_DATA} rx_state_e;

  localparam logic [3:0] CODE_WRITE = 4'd1;
  localparam logic [3:0] CODE_READ  = 4'd2;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  // Goes high one cycle after reset release; gates both ready outputs.
  logic alive_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) alive_q <= 1'b0;
    else      alive_q <= 1'b1;
  end

  // ---------------------------------------------------------------- TX path
  tx_state_e   tx_state_q, tx_state_d;
  logic [1:0]  tx_idx_q, tx_idx_d;
  logic [31:0] cmd_dw_q, cmd_dw_d;
  logic [31:0] cmd_addr_q, cmd_addr_d;
  logic [31:0] wr_word_q, wr_word_d;
  logic        word_full_q, word_full_d;
  logic [23:0] tx_left_q, tx_left_d;

  logic        cmd_ready_c;
  logic        wr_ready_c;
  logic        tx_valid_c;
  logic [7:0]  tx_byte_c;
  logic [3:0]  cur_code;

  assign cur_code = cmd_dw_q[27:24];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q  <= TX_IDLE;
      tx_idx_q    <= 2'd0;
      cmd_dw_q    <= 32'd0;
      cmd_addr_q  <= 32'd0;
      wr_word_q   <= 32'd0;
      word_full_q <= 1'b0;
      tx_left_q   <= 24'd0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_idx_q    <= tx_idx_d;
      cmd_dw_q    <= cmd_dw_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_word_q   <= wr_word_d;
      word_full_q <= word_full_d;
      tx_left_q   <= tx_left_d;
    end
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_idx_d    = tx_idx_q;
    cmd_dw_d    = cmd_dw_q;
    cmd_addr_d  = cmd_addr_q;
    wr_word_d   = wr_word_q;
    word_full_d = word_full_q;
    tx_left_d   = tx_left_q;
    cmd_ready_c = 1'b0;
    wr_ready_c  = 1'b0;
    tx_valid_c  = 1'b0;
    tx_byte_c   = 8'h00;
    case (tx_state_q)
      TX_IDLE: begin
        cmd_ready_c = alive_q;
        if (bus.cmd_valid && alive_q) begin
          cmd_dw_d   = {bus.cmd_flags, bus.cmd_code, bus.cmd_count};
          cmd_addr_d = bus.cmd_address;
          tx_left_d  = (bus.cmd_count == 24'd0) ? 24'd1 : bus.cmd_count;
          tx_idx_d   = 2'd0;
          tx_state_d = TX_ID;
        end
      end
      TX_ID: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = CMD_ID;
        if (bus.tx_ready) begin
          tx_idx_d   = 2'd0;
          tx_state_d = TX_CMD;
        end
      end
      TX_CMD: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = pick_byte(cmd_dw_q, tx_idx_q);
        if (bus.tx_ready) begin
          tx_idx_d = tx_idx_q + 2'd1;
          if (tx_idx_q == 2'd3) begin
            if (cur_code == CODE_WRITE || cur_code == CODE_READ) tx_state_d = TX_ADDR;
            else                                                 tx_state_d = TX_IDLE;
          end
        end
      end
      TX_ADDR: begin
        tx_valid_c = 1'b1;
        tx_byte_c  = pick_byte(cmd_addr_q, tx_idx_q);
        if (bus.tx_ready) begin
          tx_idx_d = tx_idx_q + 2'd1;
          if (tx_idx_q == 2'd3) begin
            word_full_d = 1'b0;
            tx_state_d  = (cur_code == CODE_WRITE) ? TX_DATA : TX_IDLE;
          end
        end
      end
      TX_DATA: begin
        // At a word boundary the stream stalls (tx_valid low) until a payload word is taken.
        if (!word_full_q) begin
          wr_ready_c = bus.wr_valid;
          if (bus.wr_valid) begin
            wr_word_d   = bus.wr_data;
            word_full_d = 1'b1;
          end
        end else begin
          tx_valid_c = 1'b1;
          tx_byte_c  = pick_byte(wr_word_q, tx_idx_q);
          if (bus.tx_ready) begin
            tx_idx_d = tx_idx_q + 2'd1;
            if (tx_idx_q == 2'd3) begin
              word_full_d = 1'b0;
              if (tx_left_q == 24'd1) tx_state_d = TX_IDLE;
              else                    tx_left_d  = tx_left_q - 24'd1;
            end
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_c;
  assign bus.wr_ready  = wr_ready_c;
  assign bus.tx_valid  = tx_valid_c;
  assign bus.tx_byte   = tx_byte_c;

  // ---------------------------------------------------------------- RX path
  rx_state_e   rx_state_q, rx_state_d;
  logic [1:0]  rx_idx_q, rx_idx_d;
  logic [23:0] rx_shift_q, rx_shift_d;
  logic [23:0] rx_left_q, rx_left_d;
  logic [7:0]  rsp_status_q, rsp_status_d;
  logic [23:0] rsp_count_q, rsp_count_d;
  logic [31:0] rsp_address_q, rsp_address_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_data_valid_q, rsp_data_valid_d;
  logic        rsp_done_q, rsp_done_d;
  logic        rsp_bad_q, rsp_bad_d;
  logic [15:0] sync_drop_q, sync_drop_d;
  logic [31:0] rx_word;

  // The word completed by the byte arriving this cycle.
  assign rx_word = {rx_shift_q, bus.rx_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q       <= RX_HUNT;
      rx_idx_q         <= 2'd0;
      rx_shift_q       <= 24'd0;
      rx_left_q        <= 24'd0;
      rsp_status_q     <= 8'd0;
      rsp_count_q      <= 24'd0;
      rsp_address_q    <= 32'd0;
      rsp_data_q       <= 32'd0;
      rsp_data_valid_q <= 1'b0;
      rsp_done_q       <= 1'b0;
      rsp_bad_q        <= 1'b0;
      sync_drop_q      <= 16'd0;
    end else begin
      rx_state_q       <= rx_state_d;
      rx_idx_q         <= rx_idx_d;
      rx_shift_q       <= rx_shift_d;
      rx_left_q        <= rx_left_d;
      rsp_status_q     <= rsp_status_d;
      rsp_count_q      <= rsp_count_d;
      rsp_address_q    <= rsp_address_d;
      rsp_data_q       <= rsp_data_d;
      rsp_data_valid_q <= rsp_data_valid_d;
      rsp_done_q       <= rsp_done_d;
      rsp_bad_q        <= rsp_bad_d;
      sync_drop_q      <= sync_drop_d;
    end
  end

  always_comb begin
    rx_state_d       = rx_state_q;
    rx_idx_d         = rx_idx_q;
    rx_shift_d       = rx_shift_q;
    rx_left_d        = rx_left_q;
    rsp_status_d     = rsp_status_q;
    rsp_count_d      = rsp_count_q;
    rsp_address_d    = rsp_address_q;
    rsp_data_d       = rsp_data_q;
    rsp_data_valid_d = 1'b0;
    rsp_done_d       = 1'b0;
    rsp_bad_d        = 1'b0;
    sync_drop_d      = sync_drop_q;
    if (bus.rx_valid && alive_q) begin
      rx_shift_d = rx_word[23:0];
      case (rx_state_q)
        RX_HUNT: begin
          if (bus.rx_byte == RSP_ID) begin
            rx_idx_d   = 2'd0;
            rx_state_d = RX_STATUS;
          end else if (sync_drop_q != 16'hFFFF) begin
            sync_drop_d = sync_drop_q + 16'd1;
          end
        end
        RX_STATUS: begin
          rx_idx_d = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'd3) begin
            rsp_status_d = rx_word[31:24];
            rsp_count_d  = rx_word[23:0];
            case (rx_word[27:24])
              4'hF, 4'hC: begin
                rsp_done_d = 1'b1;
                rx_state_d = RX_HUNT;
              end
              4'hE: begin
                rx_left_d  = 24'd1;
                rx_state_d = RX_ADDR;
              end
              4'hD: begin
                rx_left_d  = (rx_word[23:0] == 24'd0) ? 24'd1 : rx_word[23:0];
                rx_state_d = RX_ADDR;
              end
              default: begin
                rsp_bad_d  = 1'b1;
                rsp_done_d = 1'b1;
                rx_state_d = RX_HUNT;
              end
            endcase
          end
        end
        RX_ADDR: begin
          rx_idx_d = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'd3) begin
            rsp_address_d = rx_word;
            rx_state_d    = RX_DATA;
          end
        end
        RX_DATA: begin
          rx_idx_d = rx_idx_q + 2'd1;
          if (rx_idx_q == 2'd3) begin
            rsp_data_d       = rx_word;
            rsp_data_valid_d = 1'b1;
            if (rx_left_q == 24'd1) begin
              rsp_done_d = 1'b1;
              rx_state_d = RX_HUNT;
            end else begin
              rx_left_d = rx_left_q - 24'd1;
            end
          end
        end
        default: rx_state_d = RX_HUNT;
      endcase
    end
  end

  assign bus.rx_ready       = alive_q;
  assign bus.rsp_status     = rsp_status_q;
  assign bus.rsp_count      = rsp_count_q;
  assign bus.rsp_address    = rsp_address_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_data_valid = rsp_data_valid_q;
  assign bus.rsp_done       = rsp_done_q;
  assign bus.rsp_bad        = rsp_bad_q;
  assign bus.sync_drop      = sync_drop_q;

  assign dbg_tx_state_o = tx_state_q;
  assign dbg_rx_state_o = rx_state_q;

endmodule

// File: tb/tb_ft_host_framer.sv
// Randomised bench for ft_host_framer: expected TX bytes and RX response events
// are generated from command/response descriptions and compared at negedge.
module tb_ft_host_framer;
  localparam logic [7:0] CMD_ID = 8'hCD;
  localparam logic [7:0] RSP_ID = 8'hDC;

  typedef struct packed {
    logic        is_data;
    logic        done;
    logic        bad;
    logic [7:0]  status;
    logic [23:0] count;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_tx;
  logic [1:0] dbg_rx;

  ft_host_framer_if bus ();

  ft_host_framer dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus.slave),
    .dbg_tx_state_o (dbg_tx),
    .dbg_rx_state_o (dbg_rx)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
    $fatal(1);
  end

  // ---------------------------------------------------------- scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] pay_q[$];
  logic [7:0]  rx_stream[$];
  ev_t         ev_q[$];
  logic [31:0] cur_addr = 32'd0;
  int          sd_exp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void exp_push32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[31-8*i -: 8]);
  endfunction

  function automatic void rx_push32(input logic [31:0] w);
    for (int i = 0; i < 4; i++) rx_stream.push_back(w[31-8*i -: 8]);
  endfunction

  // ---------------------------------------------------------- TX driver
  task automatic run_cmd(input logic [3:0] flags, input logic [3:0] code,
                         input logic [23:0] count, input logic [31:0] addr,
                         input int stall_pct, input int abort_after, output bit aborted);
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  stall_byte;
    int n, cyc, got_bytes, wr_pulses, exp_pulses;
    bit taken, stalled, first, last_seen, finished;
    aborted = 0; got_bytes = 0; wr_pulses = 0; exp_pulses = 0;
    taken = 0; stalled = 0; first = 1; last_seen = 0; finished = 0;
    stall_byte = 8'h00;
    n = (count == 24'd0) ? 1 : int'(count);
    exp_q.push_back(CMD_ID);
    exp_push32({flags, code, count});
    if (code == 4'd1 || code == 4'd2) exp_push32(addr);
    if (code == 4'd1) begin
      exp_pulses = n;
      for (int k = 0; k < n; k++) begin
        w = (pay_q.size() > 0) ? pay_q.pop_front() : $urandom;
        words.push_back(w);
        exp_push32(w);
      end
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_flags = flags; bus.cmd_code = code;
    bus.cmd_count = count; bus.cmd_address = addr;
    bus.tx_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(1, 100) > stall_pct);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.cmd_ready && cyc < 50);
    if (!bus.cmd_ready) begin
      check("cmd_accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0;
      exp_q.delete();
      return;
    end
    @(posedge clk); #1;
    // Scramble the command inputs so the frame must come from latched copies.
    bus.cmd_valid = 1'b0; bus.cmd_flags = 4'($urandom); bus.cmd_code = 4'($urandom);
    bus.cmd_count = 24'($urandom); bus.cmd_address = $urandom;
    cyc = 0;
    while (!finished && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (first) begin
        check("id_valid", bus.tx_valid, 1);
        check("id_byte", bus.tx_byte, CMD_ID);
        first = 0;
      end
      if (last_seen) begin
        check("cmd_ready_ret", bus.cmd_ready, 1);
        check("wr_pulses", wr_pulses, exp_pulses);
        finished = 1;
      end else begin
        if (stalled) begin
          check("tx_hold", bus.tx_valid, 1);
          check("tx_stable", bus.tx_byte, stall_byte);
        end
        stalled = 0;
        if (bus.tx_valid) begin
          check("cmd_ready_busy", bus.cmd_ready, 0);
          if (bus.tx_ready) begin
            if (exp_q.size() == 0) check("tx_extra", 1, 0);
            else begin
              check("tx_byte", bus.tx_byte, exp_q.pop_front());
              got_bytes++;
              if (exp_q.size() == 0) last_seen = 1;
            end
          end else begin
            stalled = 1;
            stall_byte = bus.tx_byte;
          end
        end
        if (bus.wr_ready) begin
          check("wr_ready_valid", bus.wr_valid, 1);
          taken = 1;
          wr_pulses++;
        end
      end
      if (!finished) begin
        if (abort_after > 0 && got_bytes == abort_after) begin
          @(posedge clk); #2;
          rst = 1'b0;
          #1;
          check("rst_tx_valid", bus.tx_valid, 0);
          check("rst_cmd_ready", bus.cmd_ready, 0);
          aborted = 1;
          exp_q.delete();
          bus.wr_valid = 1'b0;
          return;
        end
        @(posedge clk); #1;
        if (taken) begin
          void'(words.pop_front());
          bus.wr_valid = 1'b0;
          taken = 0;
        end
        if (!bus.wr_valid && words.size() > 0 && $urandom_range(0, 2) != 0) begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = words[0];
        end
        bus.tx_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(1, 100) > stall_pct);
      end
    end
    if (!finished) check("tx_timeout", 0, 1);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------- RX model/driver
  task automatic rsp_add(input logic [7:0] st, input logic [23:0] cnt,
                         input logic [31:0] addr, input int garbage);
    ev_t e;
    logic [7:0] b;
    logic [31:0] w;
    int m;
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == RSP_ID) b = 8'h00;
      rx_stream.push_back(b);
      sd_exp++;
    end
    rx_stream.push_back(RSP_ID);
    rx_push32({st, cnt});
    e = '0;
    e.status = st;
    e.count  = cnt;
    case (st[3:0])
      4'hF, 4'hC: begin
        e.done = 1'b1; e.addr = cur_addr;
        ev_q.push_back(e);
      end
      4'hE, 4'hD: begin
        m = (st[3:0] == 4'hE) ? 1 : ((cnt == 24'd0) ? 1 : int'(cnt));
        rx_push32(addr);
        cur_addr = addr;
        for (int k = 0; k < m; k++) begin
          w = (pay_q.size() > 0) ? pay_q.pop_front() : $urandom;
          rx_push32(w);
          e.is_data = 1'b1; e.done = (k == m - 1); e.addr = addr; e.data = w;
          ev_q.push_back(e);
        end
      end
      default: begin
        e.done = 1'b1; e.bad = 1'b1; e.addr = cur_addr;
        ev_q.push_back(e);
      end
    endcase
  endtask

  task automatic run_rsp();
    ev_t e;
    int cyc;
    cyc = 0;
    while ((rx_stream.size() > 0 || ev_q.size() > 0) && cyc < 5000) begin
      @(posedge clk); #1;
      if (rx_stream.size() > 0 && $urandom_range(0, 3) != 0) begin
        bus.rx_valid = 1'b1;
        bus.rx_byte  = rx_stream.pop_front();
      end else begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = 8'($urandom);
      end
      @(negedge clk); cyc++;
      if (bus.rsp_data_valid || bus.rsp_done || bus.rsp_bad) begin
        if (ev_q.size() == 0) check("rx_extra", 1, 0);
        else begin
          e = ev_q.pop_front();
          check("rsp_data_valid", bus.rsp_data_valid, e.is_data);
          check("rsp_done", bus.rsp_done, e.done);
          check("rsp_bad", bus.rsp_bad, e.bad);
          check("rsp_status", bus.rsp_status, e.status);
          check("rsp_count", bus.rsp_count, e.count);
          check("rsp_address", bus.rsp_address, e.addr);
          if (e.is_data) check("rsp_data", bus.rsp_data, e.data);
        end
      end
    end
    if (cyc >= 5000) check("rx_timeout", 0, 1);
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rx_quiet", {bus.rsp_data_valid, bus.rsp_done, bus.rsp_bad}, 0);
    end
    check("sync_drop", bus.sync_drop, sd_exp);
    check("rx_ready", bus.rx_ready, 1);
  endtask

  // ---------------------------------------------------------- main sequence
  bit          ab1, ab2;
  logic [3:0]  r_code, r_flags;
  logic [23:0] r_count;
  logic [3:0]  r_nib;

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_flags = 4'h0; bus.cmd_code = 4'h0;
    bus.cmd_count = 24'd0; bus.cmd_address = 32'd0;
    bus.wr_data = 32'd0; bus.wr_valid = 1'b0; bus.tx_ready = 1'b1;
    bus.rx_byte = 8'h00; bus.rx_valid = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_byte", bus.tx_byte, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rx_ready", bus.rx_ready, 0);
    check("rst_rsp", {bus.rsp_status, bus.rsp_count, bus.rsp_data_valid, bus.rsp_done, bus.rsp_bad}, 0);
    check("rst_rsp_addr", bus.rsp_address, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_sync_drop", bus.sync_drop, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("ready_lag_cmd", bus.cmd_ready, 0);
    check("ready_lag_rx", bus.rx_ready, 0);
    @(negedge clk);
    check("ready_up_cmd", bus.cmd_ready, 1);
    check("ready_up_rx", bus.rx_ready, 1);

    // Directed command frames
    run_cmd(4'h0, 4'd0, 24'd0, 32'd0, 0, 0, ab1);
    pay_q.push_back(32'hDEADBEEF);
    pay_q.push_back(32'h01234567);
    run_cmd(4'h0, 4'd1, 24'd2, 32'h0000_0100, 50, 0, ab1);
    run_cmd(4'h0, 4'd2, 24'd0, 32'h1234_5678, 0, 0, ab1);
    run_cmd(4'hA, 4'd3, 24'h000007, 32'h0, 30, 0, ab1);

    // Directed responses
    rx_stream.push_back(8'hAA);
    rx_stream.push_back(8'h55);
    sd_exp += 2;
    pay_q.push_back(32'h11111111);
    pay_q.push_back(32'h22222222);
    rsp_add(8'h0D, 24'd2, 32'h0000_0100, 0);
    run_rsp();
    rsp_add(8'h07, 24'd0, 32'h0, 0);
    rsp_add(8'h3F, 24'h000123, 32'h0, 0);
    rsp_add(8'h0E, 24'h000009, 32'hCAFE_0000, 1);
    run_rsp();

    // Random commands and responses running concurrently
    for (int t = 0; t < 14; t++) begin
      r_code  = 4'($urandom_range(0, 7));
      r_flags = 4'($urandom);
      r_count = (r_code == 4'd1) ? 24'($urandom_range(0, 4)) : 24'($urandom);
      for (int k = 0; k < 3; k++) begin
        case ($urandom_range(0, 4))
          0: r_nib = 4'hF;
          1: r_nib = 4'hC;
          2: r_nib = 4'hE;
          3: r_nib = 4'hD;
          default: r_nib = 4'($urandom_range(0, 11));
        endcase
        rsp_add({4'($urandom), r_nib},
                (r_nib == 4'hD) ? 24'($urandom_range(0, 3)) : 24'($urandom),
                $urandom, $urandom_range(0, 3));
      end
      fork
        run_cmd(r_flags, r_code, r_count, $urandom, $urandom_range(0, 60), 0, ab1);
        run_rsp();
      join
    end

    // Reset in the middle of a WRITE, then a fresh PING
    pay_q.push_back(32'hA1B2C3D4);
    pay_q.push_back(32'h5566_7788);
    pay_q.push_back(32'h99AA_BBCC);
    run_cmd(4'h0, 4'd1, 24'd3, 32'h0000_0040, 0, 6, ab2);
    check("abort_hit", ab2, 1);
    pay_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("abort_rsp_status", bus.rsp_status, 0);
    check("abort_sync_drop", bus.sync_drop, 0);
    rst = 1'b1;
    sd_exp = 0;
    cur_addr = 32'd0;
    run_cmd(4'h0, 4'd0, 24'd0, 32'd0, 20, 0, ab1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ft_host_framer.md
# ft_host_framer

Host-side endpoint of the FT245 sync-FIFO command protocol. It serialises host commands (PING, WRITE, READ, RESET) into the 0xCD-framed byte stream the FPGA host interface consumes. It also parses the 0xDC-framed response byte stream coming back into status, address and data words. It sits between a host-side controller (or bench master) and the 8-bit FIFO byte path.

## Interface
Parameters
- `CMD_ID`, 8'hCD: start-of-command byte.
- `RSP_ID`, 8'hDC: start-of-response byte.

Ports
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in TX IDLE.
- `cmd_flags`  in  4  command dw bits [31:28].
- `cmd_code`  in  4  command dw bits [27:24]: 0 PING, 1 WRITE, 2 READ, 3 RESET.
- `cmd_count`  in  24  data-word count, command dw bits [23:0].
- `cmd_address`  in  32  address dw.
- `wr_data`  in  32  write payload word.
- `wr_valid`  in  1  payload word available.
- `wr_ready`  out  1  one-cycle pulse: `wr_data` taken.
- `tx_byte`  out  8  outgoing byte.
- `tx_valid`  out  1  `tx_byte` valid.
- `tx_ready`  in  1  sink accepts byte.
- `rx_byte`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_byte` valid.
- `rx_ready`  out  1  1 whenever out of reset.
- `rsp_status`  out  8  response dw [31:24].
- `rsp_count`  out  24  response dw [23:0].
- `rsp_address`  out  32  response address.
- `rsp_data`  out  32  response data word.
- `rsp_data_valid`  out  1  pulse per data word.
- `rsp_done`  out  1  pulse at end of response.
- `rsp_bad`  out  1  pulse: unknown status nibble.
- `sync_drop`  out  16  saturating count of bytes discarded while hunting.

## Operation
- Multi-byte words are sent and received MSB first.
- Command dw is {cmd_flags, cmd_code, cmd_count}.
- Effective data count is N = cmd_count, except N = 1 when cmd_count = 0.
- TX FSM states: IDLE, ID, CMD, ADDR, DATA; a 2-bit byte index is used inside word states.
  - IDLE: on cmd_valid&&cmd_ready, latch all cmd_* fields and go to ID.
  - ID: send CMD_ID, then go to CMD.
  - CMD: send 4 bytes. Codes 1 and 2 go to ADDR. All other codes go to IDLE.
  - ADDR: send 4 bytes. READ goes to IDLE. WRITE goes to DATA.
  - DATA: if wr_valid, pulse wr_ready, latch the word and send 4 bytes. Repeat N times, then go to IDLE.
  - If wr_valid is low at a word boundary, tx_valid stays 0 until a word arrives.
- Byte counts per command: PING/RESET 5 bytes; READ 9; WRITE 9+4N.
- RX FSM states: HUNT, STATUS, ADDR, DATA.
  - HUNT: discard bytes until RSP_ID, incrementing sync_drop per discard (saturates at FFFF). RSP_ID goes to STATUS.
  - STATUS: assemble 4 bytes into rsp_status/rsp_count, then branch on status[3:0]:
    - F (ping) or C (reset): pulse rsp_done, go to HUNT.
    - E (write ack): ADDR, then 1 data word.
    - D (read): ADDR, then M data words, where M = rsp_count, or 1 when rsp_count = 0.
    - Any other nibble: pulse rsp_bad and rsp_done, go to HUNT.
  - DATA: pulse rsp_data_valid with each word. rsp_done pulses in the same cycle as the last word's rsp_data_valid.
- TX and RX are independent; both may be active simultaneously.

## Timing
- Reset values: cmd_ready 0, wr_ready 0, tx_valid 0, tx_byte 00, rx_ready 0, all rsp_* 0, sync_drop 0. Both FSMs return to IDLE/HUNT.
- One cycle after reset deasserts, cmd_ready and rx_ready go 1.
- TX handshake and latency:
  - The cycle after command accept, tx_valid=1 and tx_byte=CMD_ID.
  - A byte advances only on tx_valid&&tx_ready. tx_byte is held stable while tx_ready=0.
  - The next byte appears the cycle after acceptance; back-to-back bytes are possible.
  - cmd_ready returns 1 the cycle after the last byte is accepted.
- wr_ready pulses in the cycle the word is latched. Its first byte is on tx_byte the next cycle.
- RX:
  - A byte is consumed on every rx_valid cycle.
  - Registered rsp_* outputs update the cycle after the completing byte. Pulses last exactly one cycle.
  - rsp_status, rsp_count and rsp_address hold until overwritten.
- Reset asserted mid-frame aborts both directions immediately; no partial-frame resume.

## Test plan
- PING, flags 0, count 0 -> tx bytes CD 00 00 00 00; cmd_ready back high after 5th accept.
- WRITE, count 2, addr 0x00000100, data 0xDEADBEEF, 0x01234567, tx_ready toggling 50% -> CD 01 00 00 02 00 00 01 00 DE AD BE EF 01 23 45 67; bytes stable during stalls; two wr_ready pulses.
- READ, count 0, addr 0x12345678 -> CD 02 00 00 00 12 34 56 78; no wr_ready.
- RX bytes AA 55 DC 0D 00 00 02 00 00 01 00 11 11 11 11 22 22 22 22 -> sync_drop=2; rsp_status 0D, rsp_count 2, address 0x100; two data pulses; rsp_done with the second.
- RX DC 07 00 00 00 -> rsp_bad and rsp_done pulse; FSM returns to HUNT.
- Reset asserted mid-WRITE after 6 bytes -> tx_valid 0 asynchronously; after release, a new PING frames correctly.
